// File: rtl/bus_arbiter_mux.sv
// Multi-source bus arbiter and data mux with fixed-priority or round-robin
// selection, grant locking via hold, and a saturating conflict counter.
module bus_arbiter_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 24,
  parameter int unsigned MODE  = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  input  logic               hold,
  input  logic               cnt_clr,
  output logic [WIDTH-1:0]   bus_out,
  output logic [N-1:0]       grant,
  output logic [4:0]         grant_idx,
  output logic               bus_valid,
  output logic               conflict,
  output logic [7:0]         conflict_cnt
);

  logic [WIDTH-1:0] bus_q, bus_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [4:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       ptr_q, ptr_d;

  logic             req_at_idx;
  logic             locked;
  logic [N-1:0]     hi_mask;
  logic [N-1:0]     req_hi;
  logic [N-1:0]     sel;
  logic             found;
  logic [4:0]       win;
  logic [4:0]       src;
  logic [WIDTH-1:0] src_data;

  always_comb begin
    req_at_idx = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (5'(i) == idx_q) req_at_idx = req[i];
    end
    locked = hold && valid_q && req_at_idx;

    // Round-robin: prefer requests at or above ptr, else wrap to the lowest request.
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (MODE == 1) ? (5'(i) >= ptr_q) : 1'b1;
    end
    req_hi = req & hi_mask;
    sel    = (|req_hi) ? req_hi : req;
    found  = |sel;

    win = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (sel[i-1]) win = 5'(i - 1);
    end

    src      = locked ? idx_q : win;
    src_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (5'(i) == src) src_data = din[i*WIDTH +: WIDTH];
    end

    grant_d    = grant_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    bus_d      = src_data;
    conflict_d = 1'b0;
    ptr_d      = ptr_q;

    if (!locked) begin
      if (found) begin
        for (int unsigned i = 0; i < N; i++) begin
          grant_d[i] = (5'(i) == win);
        end
        idx_d      = win;
        valid_d    = 1'b1;
        conflict_d = |(req & (req - N'(1)));
        if (MODE == 1) begin
          ptr_d = (win == 5'(N - 1)) ? '0 : win + 5'd1;
        end
      end else begin
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        bus_d   = '0;
      end
    end

    if (MODE != 1) ptr_d = '0;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (conflict_d && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_q      <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      bus_q      <= bus_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus_out      = bus_q;
  assign grant        = grant_q;
  assign grant_idx    = idx_q;
  assign bus_valid    = valid_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule
